pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Stall/flush controller for the 5-stage pipeline. It consumes the load-use `Pause` from the hazard detector, the EX-stage branch redirect, and the MEM-stage IO handshake. From these it drives the write-enable and flush controls of the PC and every pipeline register, using a small FSM that enforces bubble counts, IO wait and timeout. It also keeps stall and flush performance counters.

## Interface
- `IO_TIMEOUT`, 255: max cycles spent in IO_WAIT before forced release
- `CNT_W`, 32: performance counter width
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `Pause`  in  1  load-use hazard, MEM load vs EX operand
- `EX_branch_taken`  in  1  branch/jump resolved taken in EX
- `MEM_io_req`  in  1  MEM-stage instruction is an IO read or write
- `io_ready`  in  1  IO device has completed the access
- `PC_write`  out  1  PC update enable
- `IF_ID_write`  out  1  IF/ID hold when 0
- `IF_ID_flush`  out  1  IF/ID load NOP
- `ID_EX_write`  out  1  ID/EX hold when 0
- `ID_EX_flush`  out  1  ID/EX load NOP
- `EX_MEM_write`  out  1  EX/MEM hold when 0
- `EX_MEM_flush`  out  1  EX/MEM load NOP (bubble)
- `MEM_WB_flush`  out  1  MEM/WB load NOP
- `io_timeout`  out  1  sticky error flag
- `stall_cycles`  out  CNT_W  cycles with `PC_write`=0
- `flush_count`  out  CNT_W  taken-branch flush events

## Operation
- FSM states: RUN, LU_STALL, IO_WAIT.
- **RUN, priority order:**
  - **IO wait:** if `MEM_io_req` and `io_ready`=0, go to IO_WAIT. In the same cycle freeze PC, IF_ID, ID_EX and EX_MEM, and assert `MEM_WB_flush`.
  - **Load-use:** else if `Pause`, go to LU_STALL. In the same cycle freeze PC, IF_ID and ID_EX, and assert `EX_MEM_flush`.
  - **Branch:** else if `EX_branch_taken`, assert `IF_ID_flush` and `ID_EX_flush`, keep all write enables at 1, stay in RUN, and increment `flush_count`.
  - **Default:** otherwise all writes 1 and all flushes 0.
- **LU_STALL:** lasts exactly one cycle, then returns to RUN.
  - Outputs are as in RUN.
  - `Pause` is masked for this cycle, so one load yields exactly one bubble.
  - IO wait priority still applies: an IO wait condition here goes to IO_WAIT instead.
- **IO_WAIT:** PC, IF_ID, ID_EX and EX_MEM are frozen and `MEM_WB_flush`=1.
  - A timeout counter increments each cycle.
  - When `io_ready`=1, the cycle's outputs equal RUN defaults and the FSM returns to RUN.
  - When the counter reaches `IO_TIMEOUT`, set `io_timeout`, release to RUN, and clear the counter.
- **Branch versus stall:** `EX_branch_taken` is ignored in LU_STALL entry cycles and in IO_WAIT, because the EX instruction is stalled and its operands are invalid. The branch is honoured once EX advances.
- **Performance counters:** `stall_cycles` increments on every cycle with `PC_write`=0. Both counters wrap modulo 2^CNT_W.
- A write enable of 0 and a flush of 1 on the same register never occur together, except in these cases:
  - EX_MEM_flush with EX_MEM_write=1.
  - MEM_WB_flush, which has no write enable.

## Timing
- **Outputs:** all control outputs are combinational from the state and the current inputs, so they act in the same cycle.
  - State, timeout counter, `io_timeout` and the performance counters are registered.
- **Reset:** applies at the first `clk` edge with `rst`=1.
  - State RUN, timeout counter 0, `io_timeout`=0, `stall_cycles`=0, `flush_count`=0.
  - While `rst`=1, all write enables are 1 and all flushes are 0.
- **Reset mid-IO_WAIT:** next cycle the FSM is in RUN with counters cleared.
- **Load-use latency:** 1 stall cycle per hazard.
- **IO latency:** N stall cycles, where `io_ready` rises N cycles after entry.
  - N=0 means `io_ready` is already high on entry, so no stall occurs.
  - N is at most `IO_TIMEOUT`.
- **Branch penalty:** 2 flushed instructions, with no stall cycle.
- **Simultaneous events:** IO wait beats `Pause`, and `Pause` beats branch.
- **Timeout boundary:** `io_ready` and timeout in the same cycle counts as a normal completion; `io_timeout` stays 0.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the 2-bit state encodings (RUN=0, LU_STALL=1, IO_WAIT=2);
  - the NOP instruction constant used by the pipeline registers.
- Sub-module `perf_counter`: a CNT_W-bit counter with synchronous reset and an increment enable. It is instantiated twice, once for `stall_cycles` and once for `flush_count`.

## Test plan
- **Reset:** assert `rst` 2 cycles with `Pause`=1 → all writes=1, flushes=0, counters=0.
- **Load-use:** `Pause` held high for 3 cycles → exactly 1 cycle of `PC_write`=0 and `EX_MEM_flush`=1, then the mask cycle, then a new stall; `stall_cycles`=2.
- **Taken branch:** `EX_branch_taken` for 1 cycle → `IF_ID_flush`=`ID_EX_flush`=1 for that cycle, `PC_write`=1, `flush_count`=1.
- **IO wait:** `MEM_io_req`=1 with `io_ready` rising after 5 cycles → 5 frozen cycles with `MEM_WB_flush`=1, release on the 6th cycle, `stall_cycles`=5.
- **IO timeout:** `IO_TIMEOUT`=8 with `io_ready` held 0 → release after 8 cycles, `io_timeout` sticky 1 until reset.
- **Simultaneous events:** `Pause`, `EX_branch_taken` and a pending IO access in the same cycle → IO_WAIT entered, branch not flushed, `flush_count` unchanged. Separately, `rst` during IO_WAIT → RUN next cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
// State encodings and the NOP loaded into flushed pipeline registers.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_IO_WAIT  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter with synchronous clear.
// Wraps modulo 2^CNT_W.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: load-use bubbles, IO wait with timeout,
// taken-branch flushes, plus stall and flush performance counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int IO_TIMEOUT = 255,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Pause,
  input  logic             EX_branch_taken,
  input  logic             MEM_io_req,
  input  logic             io_ready,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_write,
  output logic             ID_EX_flush,
  output logic             EX_MEM_write,
  output logic             EX_MEM_flush,
  output logic             MEM_WB_flush,
  output logic             io_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int TW = $clog2(IO_TIMEOUT + 1);

  state_t        state, state_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic          to_set;
  logic          io_hold, lu_hold, br_flush;
  logic          io_pend, lu_req, br_req;

  assign io_pend = MEM_io_req & ~io_ready;
  // Pause is masked in LU_STALL so one load yields one bubble
  assign lu_req  = Pause & (state == ST_RUN) & ~io_pend;
  assign br_req  = EX_branch_taken & ~io_pend & ~lu_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      tcnt       <= '0;
      io_timeout <= 1'b0;
    end else begin
      state      <= state_nx;
      tcnt       <= tcnt_nx;
      io_timeout <= io_timeout | to_set;
    end
  end

  always_comb begin
    state_nx = state;
    tcnt_nx  = tcnt;
    to_set   = 1'b0;
    io_hold  = 1'b0;
    lu_hold  = 1'b0;
    br_flush = 1'b0;
    unique case (state)
      ST_RUN, ST_LU_STALL: begin
        state_nx = ST_RUN;
        tcnt_nx  = '0;
        unique case (1'b1)
          io_pend: begin
            state_nx = ST_IO_WAIT;
            tcnt_nx  = TW'(1);
            io_hold  = 1'b1;
          end
          lu_req: begin
            state_nx = ST_LU_STALL;
            lu_hold  = 1'b1;
          end
          br_req: begin
            br_flush = 1'b1;
          end
          default: ;
        endcase
      end
      ST_IO_WAIT: begin
        // io_ready wins over an expiring timeout
        if (io_ready) begin
          state_nx = ST_RUN;
          tcnt_nx  = '0;
        end else if (tcnt == TW'(IO_TIMEOUT)) begin
          state_nx = ST_RUN;
          tcnt_nx  = '0;
          to_set   = 1'b1;
        end else begin
          io_hold = 1'b1;
          tcnt_nx = tcnt + TW'(1);
        end
      end
      default: begin
        state_nx = ST_RUN;
        tcnt_nx  = '0;
      end
    endcase
  end

  assign PC_write     = rst | ~(io_hold | lu_hold);
  assign IF_ID_write  = rst | ~(io_hold | lu_hold);
  assign ID_EX_write  = rst | ~(io_hold | lu_hold);
  assign EX_MEM_write = rst | ~io_hold;
  assign IF_ID_flush  = ~rst & br_flush;
  assign ID_EX_flush  = ~rst & br_flush;
  assign EX_MEM_flush = ~rst & lu_hold;
  assign MEM_WB_flush = ~rst & io_hold;

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~PC_write),
    .count (stall_cycles)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (IF_ID_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with IO_TIMEOUT=8.
// Control outputs packed as {PC,IFw,IFf,IDw,IDf,EXw,EXf,WBf}.
module tb_pipeline_ctrl;

  localparam logic [7:0] C_DEF = 8'hD4;
  localparam logic [7:0] C_LU  = 8'h06;
  localparam logic [7:0] C_BR  = 8'hFC;
  localparam logic [7:0] C_IO  = 8'h01;

  logic        clk;
  logic        rst;
  logic        Pause, EX_branch_taken, MEM_io_req, io_ready;
  logic        PC_write, IF_ID_write, IF_ID_flush;
  logic        ID_EX_write, ID_EX_flush;
  logic        EX_MEM_write, EX_MEM_flush, MEM_WB_flush;
  logic        io_timeout;
  logic [31:0] stall_cycles, flush_count;
  logic [7:0]  ctl;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(.IO_TIMEOUT(8), .CNT_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .Pause           (Pause),
    .EX_branch_taken (EX_branch_taken),
    .MEM_io_req      (MEM_io_req),
    .io_ready        (io_ready),
    .PC_write        (PC_write),
    .IF_ID_write     (IF_ID_write),
    .IF_ID_flush     (IF_ID_flush),
    .ID_EX_write     (ID_EX_write),
    .ID_EX_flush     (ID_EX_flush),
    .EX_MEM_write    (EX_MEM_write),
    .EX_MEM_flush    (EX_MEM_flush),
    .MEM_WB_flush    (MEM_WB_flush),
    .io_timeout      (io_timeout),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  assign ctl = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write,
                ID_EX_flush, EX_MEM_write, EX_MEM_flush, MEM_WB_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    {Pause, EX_branch_taken, MEM_io_req, io_ready} = 4'b1000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (ctl !== C_DEF) begin
        errors++;
        $display("FAIL reset[%0d] ctl got %h exp %h", i, ctl, C_DEF);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    {Pause, EX_branch_taken, MEM_io_req, io_ready} = 4'b0000;
    #1;
    checks++;
    if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d/%0d exp 0/0",
               stall_cycles, flush_count);
    end
    checks++;
    if (io_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_to got %b exp 0", io_timeout);
    end
  endtask

  task automatic test_load_use();
    logic [3:0] vi [4] = '{4'b1000, 4'b1000, 4'b1000, 4'b0000};
    logic [7:0] ve [4] = '{C_LU, C_DEF, C_LU, C_DEF};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      {Pause, EX_branch_taken, MEM_io_req, io_ready} = vi[i];
      #1;
      checks++;
      if (ctl !== ve[i]) begin
        errors++;
        $display("FAIL load_use[%0d] ctl got %h exp %h", i, ctl, ve[i]);
      end
    end
    checks++;
    if (stall_cycles !== 32'd2) begin
      errors++;
      $display("FAIL load_use_stall got %0d exp 2", stall_cycles);
    end
  endtask

  task automatic test_branch();
    logic [3:0] vi [2] = '{4'b0100, 4'b0000};
    logic [7:0] ve [2] = '{C_BR, C_DEF};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      {Pause, EX_branch_taken, MEM_io_req, io_ready} = vi[i];
      #1;
      checks++;
      if (ctl !== ve[i]) begin
        errors++;
        $display("FAIL branch[%0d] ctl got %h exp %h", i, ctl, ve[i]);
      end
    end
    checks++;
    if (flush_count !== 32'd1 || stall_cycles !== 32'd2) begin
      errors++;
      $display("FAIL branch_cnt got %0d/%0d exp 1/2",
               flush_count, stall_cycles);
    end
  endtask

  task automatic test_io_wait();
    logic [3:0] vi [7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010,
                           4'b0010, 4'b0011, 4'b0000};
    logic [7:0] ve [7] = '{C_IO, C_IO, C_IO, C_IO, C_IO, C_DEF, C_DEF};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      {Pause, EX_branch_taken, MEM_io_req, io_ready} = vi[i];
      #1;
      checks++;
      if (ctl !== ve[i]) begin
        errors++;
        $display("FAIL io_wait[%0d] ctl got %h exp %h", i, ctl, ve[i]);
      end
    end
    checks++;
    if (stall_cycles !== 32'd7 || io_timeout !== 1'b0) begin
      errors++;
      $display("FAIL io_wait_cnt got %0d/%b exp 7/0",
               stall_cycles, io_timeout);
    end
  endtask

  task automatic test_timeout_boundary();
    logic [3:0] vi [10];
    logic [7:0] ve [10];
    for (int i = 0; i < 8; i++) begin
      vi[i] = 4'b0010;
      ve[i] = C_IO;
    end
    vi[8] = 4'b0011; ve[8] = C_DEF;
    vi[9] = 4'b0000; ve[9] = C_DEF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      {Pause, EX_branch_taken, MEM_io_req, io_ready} = vi[i];
      #1;
      checks++;
      if (ctl !== ve[i]) begin
        errors++;
        $display("FAIL boundary[%0d] ctl got %h exp %h", i, ctl, ve[i]);
      end
    end
    checks++;
    if (stall_cycles !== 32'd15 || io_timeout !== 1'b0) begin
      errors++;
      $display("FAIL boundary_cnt got %0d/%b exp 15/0",
               stall_cycles, io_timeout);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] vi [10];
    logic [7:0] ve [10];
    for (int i = 0; i < 8; i++) begin
      vi[i] = 4'b0010;
      ve[i] = C_IO;
    end
    vi[8] = 4'b0000; ve[8] = C_DEF;
    vi[9] = 4'b0000; ve[9] = C_DEF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      {Pause, EX_branch_taken, MEM_io_req, io_ready} = vi[i];
      #1;
      checks++;
      if (ctl !== ve[i]) begin
        errors++;
        $display("FAIL timeout[%0d] ctl got %h exp %h", i, ctl, ve[i]);
      end
    end
    checks++;
    if (stall_cycles !== 32'd23 || io_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_cnt got %0d/%b exp 23/1",
               stall_cycles, io_timeout);
    end
  endtask

  task automatic test_lu_mix();
    logic [3:0] vi [6] = '{4'b1100, 4'b1100, 4'b1000,
                           4'b0010, 4'b0011, 4'b0000};
    logic [7:0] ve [6] = '{C_LU, C_BR, C_LU, C_IO, C_DEF, C_DEF};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      {Pause, EX_branch_taken, MEM_io_req, io_ready} = vi[i];
      #1;
      checks++;
      if (ctl !== ve[i]) begin
        errors++;
        $display("FAIL lu_mix[%0d] ctl got %h exp %h", i, ctl, ve[i]);
      end
    end
    checks++;
    if (stall_cycles !== 32'd26 || flush_count !== 32'd2) begin
      errors++;
      $display("FAIL lu_mix_cnt got %0d/%0d exp 26/2",
               stall_cycles, flush_count);
    end
    checks++;
    if (io_timeout !== 1'b1) begin
      errors++;
      $display("FAIL sticky_to got %b exp 1", io_timeout);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] vi [4] = '{4'b1110, 4'b0100, 4'b0011, 4'b0000};
    logic [7:0] ve [4] = '{C_IO, C_IO, C_DEF, C_DEF};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      {Pause, EX_branch_taken, MEM_io_req, io_ready} = vi[i];
      #1;
      checks++;
      if (ctl !== ve[i]) begin
        errors++;
        $display("FAIL simul[%0d] ctl got %h exp %h", i, ctl, ve[i]);
      end
    end
    checks++;
    if (stall_cycles !== 32'd28 || flush_count !== 32'd2) begin
      errors++;
      $display("FAIL simul_cnt got %0d/%0d exp 28/2",
               stall_cycles, flush_count);
    end
  endtask

  task automatic test_reset_mid_io();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      {Pause, EX_branch_taken, MEM_io_req, io_ready} = 4'b0010;
      #1;
      checks++;
      if (ctl !== C_IO) begin
        errors++;
        $display("FAIL rst_io[%0d] ctl got %h exp %h", i, ctl, C_IO);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ctl !== C_DEF) begin
      errors++;
      $display("FAIL rst_io_hold ctl got %h exp %h", ctl, C_DEF);
    end
    @(negedge clk);
    rst = 1'b0;
    {Pause, EX_branch_taken, MEM_io_req, io_ready} = 4'b0000;
    #1;
    checks++;
    if (ctl !== C_DEF) begin
      errors++;
      $display("FAIL rst_io_run ctl got %h exp %h", ctl, C_DEF);
    end
    checks++;
    if (stall_cycles !== 32'd0 || flush_count !== 32'd0 ||
        io_timeout !== 1'b0) begin
      errors++;
      $display("FAIL rst_io_cnt got %0d/%0d/%b exp 0/0/0",
               stall_cycles, flush_count, io_timeout);
    end
  endtask

  initial begin
    rst = 1'b1;
    {Pause, EX_branch_taken, MEM_io_req, io_ready} = 4'b0000;
    test_reset();
    test_load_use();
    test_branch();
    test_io_wait();
    test_timeout_boundary();
    test_timeout();
    test_lu_mix();
    test_simultaneous();
    test_reset_mid_io();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
